dmem_resp: RTL and testbench

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_if.sv | 13 +
 rtl/dmem_ram.sv | 26 ++
 rtl/dmem_resp.sv | 141 ++++++++++++++
 tb/tb_dmem_resp.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data memory responder
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam logic [31:0] CNT_ADDR            = 32'hFFFF_FFF0;
  localparam int          DEFAULT_DEPTH_WORDS = 1024;
  localparam int          DEFAULT_WAIT_CYCLES = 1;

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - CPU data-memory request/response bus
interface dmem_if;
  logic        req;
  logic [31:0] daddr;
  logic [3:0]  dwe;
  logic [31:0] dwdata;
  logic [31:0] drdata;
  logic        ready;
  logic        err;

  modport master (output req, daddr, dwe, dwdata, input drdata, ready, err);
  modport slave  (input req, daddr, dwe, dwdata, output drdata, ready, err);
endinterface

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - byte-lane storage, synchronous per-lane write, combinational read
module dmem_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  // One array per lane so each lane has exactly one writer.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we[i]) begin
        lane_mem[addr] <= wdata[8*i +: 8];
      end
    end

    assign rdata[8*i +: 8] = lane_mem[addr];
  end

endmodule

// File: rtl/dmem_resp.sv
// rtl/dmem_resp.sv - wait-state data memory responder; DMEM_CYCLE_COUNTER_EN maps a cycle counter at CNT_ADDR
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input logic   clk,
  input logic   reset,
  dmem_if.slave bus
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  dwe_q, dwe_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] drdata_q, drdata_d;
  logic        err_q, err_d;

  logic [29:0] word_idx;
  logic        in_range;
  logic        cnt_hit;
  logic [31:0] cnt_value;
  logic [31:0] ram_rdata;
  logic [3:0]  ram_we;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        unused_addr_bits;

  assign word_idx         = addr_q[31:2];
  assign in_range         = {2'b00, word_idx} < 32'(DEPTH_WORDS);
  assign unused_addr_bits = ^addr_q[1:0];

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;

  assign cycle_cnt_d = cycle_cnt_q + 32'd1;
  assign cnt_hit     = (word_idx == CNT_ADDR[31:2]);
  assign cnt_value   = cycle_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q <= 32'd0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
    end
  end
`else
  assign cnt_hit   = 1'b0;
  assign cnt_value = 32'd0;
`endif

  // Writes commit on the edge leaving RESP, so the RESP-cycle read returns the old word.
  assign ram_we = (state_q == ST_RESP && in_range && !cnt_hit && !reset) ? dwe_q : 4'b0000;

  dmem_ram #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (word_idx[AW-1:0]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    resp_data = 32'd0;
    resp_err  = 1'b1;
    if (cnt_hit) begin
      resp_data = cnt_value;
      resp_err  = 1'b0;
    end else if (in_range) begin
      resp_data = ram_rdata;
      resp_err  = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    dwe_d      = dwe_q;
    wdata_d    = wdata_q;
    drdata_d   = drdata_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          addr_d     = bus.daddr;
          dwe_d      = bus.dwe;
          wdata_d    = bus.dwdata;
          wait_cnt_d = 4'd0;
          state_d    = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'(WAIT_CYCLES - 1)) begin
          state_d = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      ST_RESP: begin
        drdata_d = resp_data;
        err_d    = resp_err;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      addr_q     <= 32'd0;
      dwe_q      <= 4'd0;
      wdata_q    <= 32'd0;
      drdata_q   <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      dwe_q      <= dwe_d;
      wdata_q    <= wdata_d;
      drdata_q   <= drdata_d;
      err_q      <= err_d;
    end
  end

  // Outside RESP the last response is held.
  assign bus.ready  = (state_q == ST_RESP);
  assign bus.drdata = (state_q == ST_RESP) ? resp_data : drdata_q;
  assign bus.err    = (state_q == ST_RESP) ? resp_err : err_q;

endmodule

// File: tb/tb_dmem_resp.sv
// tb/tb_dmem_resp.sv - scoreboard bench for dmem_resp (WAIT_CYCLES=1 and WAIT_CYCLES=0 instances)
module tb_dmem_resp;
  import dmem_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        err;
    bit          chk;
  } exp_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  dmem_if bus ();
  dmem_if bus0 ();

  dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut  (.clk(clk), .reset(reset), .bus(bus));
  dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

  exp_t        sb_q[$];
  logic [31:0] model1 [int];
  logic [31:0] model0 [int];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t predict(input bit sel0, input logic [31:0] addr,
                                   input logic [3:0] we, input logic [31:0] wd);
    exp_t        e;
    int          idx;
    bit          known;
    logic [31:0] old;
    logic [31:0] nw;
    idx    = int'(addr[31:2]);
    e.data = 32'd0;
    e.err  = 1'b1;
    e.chk  = 1'b1;
    if (addr[31:2] < 30'd1024) begin
      known = sel0 ? model0.exists(idx) : model1.exists(idx);
      old   = known ? (sel0 ? model0[idx] : model1[idx]) : 32'd0;
      e.err = 1'b0;
      e.data = old;
      e.chk = known;
      if (we != 4'b0000 && (known || we == 4'hF)) begin
        nw = old;
        for (int i = 0; i < 4; i++) if (we[i]) nw[8*i +: 8] = wd[8*i +: 8];
        if (sel0) model0[idx] = nw;
        else model1[idx] = nw;
      end
    end
    return e;
  endfunction

  task automatic do_access(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                           output logic [31:0] rd, output logic e, output int lat);
    @(negedge clk);
    bus.req    = 1'b1;
    bus.daddr  = a;
    bus.dwe    = w;
    bus.dwdata = d;
    @(negedge clk);
    bus.req = 1'b0;
    lat = 1;
    while (bus.ready !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = bus.drdata;
    e  = bus.err;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req = 1'b0;  bus.daddr = 32'd0;  bus.dwe = 4'd0;  bus.dwdata = 32'd0;
    bus0.req = 1'b0; bus0.daddr = 32'd0; bus0.dwe = 4'd0; bus0.dwdata = 32'd0;
    repeat (3) @(negedge clk);
    n_tests++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus.ready); end
    n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
    n_tests++; if (bus.drdata !== 32'd0) begin n_fail++; $display("FAIL reset_drdata: got %h want 0", bus.drdata); end
    n_tests++; if (bus0.ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready0: got %b want 0", bus0.ready); end
    n_tests++; if (bus0.drdata !== 32'd0) begin n_fail++; $display("FAIL reset_drdata0: got %h want 0", bus0.drdata); end
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    logic [31:0] ta [2] = '{32'h10, 32'h10};
    logic [3:0]  tw [2] = '{4'hF, 4'h0};
    logic [31:0] td [2] = '{32'hDEADBEEF, 32'h0};
    logic [31:0] rd;
    logic        e;
    int          lat;
    exp_t        ex;
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back(predict(1'b0, ta[i], tw[i], td[i]));
      do_access(ta[i], tw[i], td[i], rd, e, lat);
      ex = sb_q.pop_front();
      n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL wr_latency[%0d]: got %0d want 2", i, lat); end
      n_tests++; if (e !== ex.err) begin n_fail++; $display("FAIL wr_err[%0d]: got %b want %b", i, e, ex.err); end
      if (ex.chk) begin
        n_tests++; if (rd !== ex.data) begin n_fail++; $display("FAIL wr_data[%0d]: got %h want %h", i, rd, ex.data); end
      end
    end
  endtask

  task automatic test_lanes();
    logic [31:0] ta [4] = '{32'h11, 32'h10, 32'h10, 32'h10};
    logic [3:0]  tw [4] = '{4'b0010, 4'h0, 4'b1001, 4'h0};
    logic [31:0] td [4] = '{32'h0000AA00, 32'h0, 32'h12345678, 32'h0};
    logic [31:0] rd;
    logic        e;
    int          lat;
    exp_t        ex;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(predict(1'b0, ta[i], tw[i], td[i]));
      do_access(ta[i], tw[i], td[i], rd, e, lat);
      ex = sb_q.pop_front();
      n_tests++; if (e !== ex.err) begin n_fail++; $display("FAIL lane_err[%0d]: got %b want %b", i, e, ex.err); end
      if (ex.chk) begin
        n_tests++; if (rd !== ex.data) begin n_fail++; $display("FAIL lane_data[%0d]: got %h want %h", i, rd, ex.data); end
      end
    end
    n_tests++; if (model1[4] !== 32'h12ADAA78) begin n_fail++; $display("FAIL lane_model: got %h want 12adaa78", model1[4]); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] ta [7] = '{32'h0, 32'hFFC, 32'h1000, 32'h1000, 32'h0, 32'hFFC, 32'h10};
    logic [3:0]  tw [7] = '{4'hF, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0};
    logic [31:0] td [7] = '{32'h0BADF00D, 32'h77665544, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0};
    logic [31:0] rd;
    logic        e;
    int          lat;
    exp_t        ex;
    for (int i = 0; i < 7; i++) begin
      sb_q.push_back(predict(1'b0, ta[i], tw[i], td[i]));
      do_access(ta[i], tw[i], td[i], rd, e, lat);
      ex = sb_q.pop_front();
      n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL oor_latency[%0d]: got %0d want 2", i, lat); end
      n_tests++; if (e !== ex.err) begin n_fail++; $display("FAIL oor_err[%0d]: got %b want %b", i, e, ex.err); end
      if (ex.chk) begin
        n_tests++; if (rd !== ex.data) begin n_fail++; $display("FAIL oor_data[%0d]: got %h want %h", i, rd, ex.data); end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t ex;
    int   k;
    int   last;
    int   pulses;
    for (int p = 0; p < 2; p++) begin
      k = 0; last = -1; pulses = 0;
      @(negedge clk);
      bus0.req    = 1'b1;
      bus0.daddr  = 32'h200;
      bus0.dwe    = (p == 0) ? 4'hF : 4'h0;
      bus0.dwdata = 32'hA5000000;
      sb_q.push_back(predict(1'b1, bus0.daddr, bus0.dwe, bus0.dwdata));
      for (int cyc = 1; cyc <= 12; cyc++) begin
        @(negedge clk);
        if (bus0.ready === 1'b1) begin
          pulses++;
          if (sb_q.size() == 0) begin
            n_tests++; n_fail++; $display("FAIL b2b_extra: got ready at cycle %0d want none", cyc);
          end else begin
            ex = sb_q.pop_front();
            n_tests++; if (bus0.err !== ex.err) begin n_fail++; $display("FAIL b2b_err: got %b want %b", bus0.err, ex.err); end
            if (ex.chk) begin
              n_tests++; if (bus0.drdata !== ex.data) begin n_fail++; $display("FAIL b2b_data: got %h want %h", bus0.drdata, ex.data); end
            end
          end
          if (last >= 0) begin
            n_tests++; if (cyc - last !== 2) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 2", cyc - last); end
          end
          last = cyc;
          k++;
          if (k < 6) begin
            bus0.daddr  = 32'h200 + 32'(k * 4);
            bus0.dwdata = 32'hA5000000 | 32'(k);
            sb_q.push_back(predict(1'b1, bus0.daddr, bus0.dwe, bus0.dwdata));
          end else begin
            bus0.req = 1'b0;
          end
        end
      end
      n_tests++; if (pulses !== 6) begin n_fail++; $display("FAIL b2b_pulses[%0d]: got %0d want 6", p, pulses); end
      n_tests++; if (sb_q.size() !== 0) begin n_fail++; $display("FAIL b2b_pending[%0d]: got %0d want 0", p, sb_q.size()); end
      sb_q.delete();
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd;
    logic        e;
    int          lat;
    exp_t        ex;
    sb_q.push_back(predict(1'b0, 32'h20, 4'hF, 32'h11223344));
    do_access(32'h20, 4'hF, 32'h11223344, rd, e, lat);
    ex = sb_q.pop_front();
    n_tests++; if (e !== ex.err) begin n_fail++; $display("FAIL abort_prewrite_err: got %b want %b", e, ex.err); end
    // Reset while WAIT.
    @(negedge clk);
    bus.req = 1'b1; bus.daddr = 32'h20; bus.dwe = 4'hF; bus.dwdata = 32'hCAFEF00D;
    @(negedge clk);
    bus.req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL abort_wait_ready: got %b want 0", bus.ready); end
    n_tests++; if (dut.state_q !== ST_IDLE) begin n_fail++; $display("FAIL abort_wait_state: got %0d want %0d", dut.state_q, ST_IDLE); end
    reset = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL abort_after_ready: got %b want 0", bus.ready); end
    // Reset while RESP.
    bus.req = 1'b1; bus.daddr = 32'h20; bus.dwe = 4'hF; bus.dwdata = 32'h55AA55AA;
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL abort_resp_ready: got %b want 1", bus.ready); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb_q.push_back(predict(1'b0, 32'h20, 4'h0, 32'h0));
    do_access(32'h20, 4'h0, 32'h0, rd, e, lat);
    ex = sb_q.pop_front();
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL abort_read_latency: got %0d want 2", lat); end
    n_tests++; if (rd !== 32'h11223344) begin n_fail++; $display("FAIL abort_word: got %h want 11223344", rd); end
  endtask

  task automatic test_counter();
    logic [31:0] v1, v2, rd;
    logic        e1, e2, e3;
    int          lat;
    do_access(CNT_ADDR, 4'h0, 32'h0, v1, e1, lat);
    repeat (7) @(negedge clk);
    do_access(CNT_ADDR, 4'h0, 32'h0, v2, e2, lat);
    do_access(CNT_ADDR, 4'hF, 32'h12345678, rd, e3, lat);
`ifdef DMEM_CYCLE_COUNTER_EN
    n_tests++; if (e1 !== 1'b0 || e2 !== 1'b0) begin n_fail++; $display("FAIL cnt_err: got %b%b want 00", e1, e2); end
    n_tests++; if (v2 - v1 !== 32'd10) begin n_fail++; $display("FAIL cnt_delta: got %0d want 10", v2 - v1); end
    n_tests++; if (e3 !== 1'b0) begin n_fail++; $display("FAIL cnt_write_err: got %b want 0", e3); end
`else
    n_tests++; if (e1 !== 1'b1 || e2 !== 1'b1) begin n_fail++; $display("FAIL cnt_err: got %b%b want 11", e1, e2); end
    n_tests++; if (v1 !== 32'd0 || v2 !== 32'd0) begin n_fail++; $display("FAIL cnt_data: got %h/%h want 0", v1, v2); end
    n_tests++; if (e3 !== 1'b1) begin n_fail++; $display("FAIL cnt_write_err: got %b want 1", e3); end
`endif
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_write_read();
    test_lanes();
    test_out_of_range();
    test_back_to_back();
    test_reset_abort();
    test_counter();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
